xgmii_rx_frame_monitor: RTL and testbench
=========================================

XGMII_RX_FRAME_MONITOR -- requirements
Module: xgmii_rx_frame_monitor

Interface
REQ-001 Parameter DATA_WIDTH, 64, XGMII data width; only 64 is supported.
REQ-002 Parameter CTRL_WIDTH, DATA_WIDTH/8, XGMII control width.
REQ-003 Parameter MAX_FRAME_BYTES, 1600, largest legal frame byte count; larger frames are marked bad.
REQ-004 Parameter FAULT_TIMEOUT, 128, consecutive beats without a fault ordered set before a fault flag clears.
REQ-005 Parameter COUNT_WIDTH, 32, width of the frame counters.
REQ-006 rx_clk  input  1  receive clock; all logic on its rising edge.
REQ-007 rx_rst  input  1  reset, asynchronous assert, active-high.
REQ-008 xgmii_rxd  input  DATA_WIDTH  receive data from the PHY RX output; lane n is bits [8n+7:8n].
REQ-009 xgmii_rxc  input  CTRL_WIDTH  receive control; bit n high means lane n is a control character.
REQ-010 cnt_clear  input  1  synchronous clear of good_count and bad_count.
REQ-011 in_frame  output  1  high while a frame is open after the current beat.
REQ-012 frame_good  output  1  one-cycle pulse when a frame closes cleanly.
REQ-013 frame_bad  output  1  one-cycle pulse when a frame closes with an error.
REQ-014 frame_len  output  16  byte count of the closed frame; valid with frame_good or frame_bad.
REQ-015 good_count, bad_count  output  COUNT_WIDTH  saturating frame counters.
REQ-016 local_fault, remote_fault  output  1  link fault status levels.

Function
REQ-017 All outputs SHALL be registered, with a latency of exactly one rx_clk after the beat that causes the update.
REQ-018 Start SHALL be 0xFB with the control bit set in lane 0 or lane 4; 0xFB in any other lane is an invalid control character.
REQ-019 Terminate SHALL be 0xFD with the control bit set in any lane; the other recognised control characters are idle 0x07, error 0xFE and sequence 0x9C.
REQ-020 State machine SHALL have two states: IDLE and FRAME.
REQ-021 In IDLE, a valid start moves the block to FRAME, clears the length and counts the data lanes above the start lane: 7 for lane 0, 3 for lane 4.
REQ-022 In FRAME, each data lane (rxc bit 0) SHALL add 1 to the length; the length saturates at 16'hFFFF.
REQ-023 Terminate in lane n SHALL close the frame, adding only the data lanes below n.
REQ-024 A closed frame is bad if it contained 0xFE, another control character before terminate, or a length above MAX_FRAME_BYTES; otherwise it is good.
REQ-025 Idle or sequence in FRAME without a preceding terminate in that beat SHALL close the frame as bad, and the block returns to IDLE.
REQ-026 A start in FRAME before any terminate SHALL close the current frame as bad and open a new frame in the same beat.
REQ-027 Terminate in lanes 0-3 followed by a start in lane 4 in the same beat SHALL close the old frame and open a new one; one result pulse is issued.
REQ-028 frame_good and frame_bad SHALL never be high in the same cycle.
REQ-029 Counters SHALL increment on their pulse and saturate at all-ones; cnt_clear has priority and drops that cycle's increment.
REQ-030 A sequence 0x9C in lane 0 with lanes 1-3 = 00,00,01 is a local fault, and with 00,00,02 is a remote fault; lane 4 uses lanes 5-7.
REQ-031 A fault flag SHALL set the cycle after its ordered set and clear after FAULT_TIMEOUT consecutive beats without it; both flags may be high together.

Reset
REQ-032 While rx_rst is high, the block SHALL be in IDLE with all outputs 0, including counters, frame_len and fault timers.
REQ-033 Reset asserted mid-frame SHALL discard the open frame without issuing a pulse.

Verification
REQ-034 Idle beats, then start in lane 0, 8 data beats, terminate in lane 0 -> frame_good=1 once, frame_len=71, good_count=1.
REQ-035 Start in lane 4, data beats, and 0xFE in a data beat before terminate -> frame_bad pulse, bad_count=1, in_frame=0 after.
REQ-036 Start, 300 all-data beats (2407 bytes), terminate -> frame_bad, frame_len=2407.
REQ-037 Terminate in lane 2 plus start in lane 4 in one beat, then a clean frame -> two frame_good pulses one frame apart, good_count=2.
REQ-038 Local fault ordered set on 3 beats, then idles -> local_fault rises the cycle after the first set and falls 128 beats after the last.
REQ-039 rx_rst asserted mid-frame, then released -> no pulse, counters 0, and the next clean frame counts as good_count=1.

Source files
------------

// File: rtl/xgmii_rx_frame_monitor.sv
// XGMII receive frame monitor.
// Watches a 64-bit XGMII receive stream and tracks frame boundaries. It reports
// a good or bad pulse with the frame byte count for each closed frame, keeps
// saturating good/bad frame counters, and holds local/remote link fault flags.
//
// Ports:
//   rx_clk, rx_rst        receive clock, async active-high reset
//   xgmii_rxd, xgmii_rxc  XGMII data (lane n = bits [8n+7:8n]) and per-lane control
//   cnt_clear             synchronous clear of good_count / bad_count
//   in_frame              frame open after the current beat
//   frame_good/frame_bad  one-cycle result pulses, frame_len valid with them
//   good_count/bad_count  saturating frame counters
//   local_fault/remote_fault  link fault status levels
module xgmii_rx_frame_monitor #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned MAX_FRAME_BYTES = 1600,
  parameter int unsigned FAULT_TIMEOUT   = 128,
  parameter int unsigned COUNT_WIDTH     = 32
) (
  input  logic                   rx_clk,
  input  logic                   rx_rst,
  input  logic [DATA_WIDTH-1:0]  xgmii_rxd,
  input  logic [CTRL_WIDTH-1:0]  xgmii_rxc,
  input  logic                   cnt_clear,
  output logic                   in_frame,
  output logic                   frame_good,
  output logic                   frame_bad,
  output logic [15:0]            frame_len,
  output logic [COUNT_WIDTH-1:0] good_count,
  output logic [COUNT_WIDTH-1:0] bad_count,
  output logic                   local_fault,
  output logic                   remote_fault
);

  localparam logic [7:0]  CharIdle  = 8'h07;
  localparam logic [7:0]  CharStart = 8'hFB;
  localparam logic [7:0]  CharTerm  = 8'hFD;
  localparam logic [7:0]  CharSeq   = 8'h9C;
  localparam logic [15:0] MaxLen    = 16'(MAX_FRAME_BYTES);
  localparam int unsigned TmrW      = $clog2(FAULT_TIMEOUT + 1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(FAULT_TIMEOUT - 1);

  typedef enum logic {StIdle, StFrame} state_e;

  state_e                 st_q, st_d;
  logic [15:0]            len_q, len_d;
  logic                   bad_q, bad_d;
  logic                   close_good, close_bad;
  logic [15:0]            close_len;
  logic [7:0]             lane_byte;
  logic [COUNT_WIDTH-1:0] good_q, good_d, badc_q, badc_d;
  logic                   in_frame_q, frame_good_q, frame_bad_q;
  logic [15:0]            frame_len_q, frame_len_d;
  logic [1:0]             fault_set;
  logic [1:0]             fault_q, fault_d;
  logic [TmrW-1:0]        tmr_q [2];
  logic [TmrW-1:0]        tmr_d [2];

  // Lanes are walked in order so that a terminate followed by a start in the
  // same beat, or a start inside an open frame, falls out of one simple rule set.
  always_comb begin
    st_d       = st_q;
    len_d      = len_q;
    bad_d      = bad_q;
    close_good = 1'b0;
    close_bad  = 1'b0;
    close_len  = len_q;
    lane_byte  = 8'h00;
    for (int i = 0; i < int'(CTRL_WIDTH); i++) begin
      lane_byte = xgmii_rxd[8*i +: 8];
      if (!xgmii_rxc[i]) begin
        if (st_d == StFrame && len_d != 16'hFFFF) len_d = len_d + 16'd1;
      end else if (st_d == StIdle) begin
        if (lane_byte == CharStart && (i == 0 || i == 4)) begin
          st_d  = StFrame;
          len_d = 16'd0;
          bad_d = 1'b0;
        end
      end else if (lane_byte == CharTerm) begin
        close_good = !(bad_d || len_d > MaxLen);
        close_bad  = bad_d || len_d > MaxLen;
        close_len  = len_d;
        st_d       = StIdle;
      end else if (lane_byte == CharStart && (i == 0 || i == 4)) begin
        // Restart inside a frame: old frame is bad, new one opens here.
        close_good = 1'b0;
        close_bad  = 1'b1;
        close_len  = len_d;
        len_d      = 16'd0;
        bad_d      = 1'b0;
      end else if (lane_byte == CharIdle || lane_byte == CharSeq) begin
        close_good = 1'b0;
        close_bad  = 1'b1;
        close_len  = len_d;
        st_d       = StIdle;
      end else begin
        // Error character or any other control inside the frame.
        bad_d = 1'b1;
      end
    end
  end

  always_comb begin
    frame_len_d = (close_good || close_bad) ? close_len : frame_len_q;
    if (cnt_clear) begin
      good_d = '0;
      badc_d = '0;
    end else begin
      good_d = (close_good && !(&good_q)) ? good_q + 1'b1 : good_q;
      badc_d = (close_bad && !(&badc_q)) ? badc_q + 1'b1 : badc_q;
    end
  end

  // Fault ordered sets: sequence in lane 0 or lane 4, then 00,00,01 (local)
  // or 00,00,02 (remote) in the three data lanes above it.
  always_comb begin
    fault_set[0] = (xgmii_rxc[3:0] == 4'b0001 && xgmii_rxd[31:0]  == 32'h0100009C) ||
                   (xgmii_rxc[7:4] == 4'b0001 && xgmii_rxd[63:32] == 32'h0100009C);
    fault_set[1] = (xgmii_rxc[3:0] == 4'b0001 && xgmii_rxd[31:0]  == 32'h0200009C) ||
                   (xgmii_rxc[7:4] == 4'b0001 && xgmii_rxd[63:32] == 32'h0200009C);
    for (int f = 0; f < 2; f++) begin
      fault_d[f] = fault_q[f];
      tmr_d[f]   = tmr_q[f];
      if (fault_set[f]) begin
        fault_d[f] = 1'b1;
        tmr_d[f]   = '0;
      end else if (fault_q[f]) begin
        if (tmr_q[f] == TmrLast) begin
          fault_d[f] = 1'b0;
          tmr_d[f]   = '0;
        end else begin
          tmr_d[f] = tmr_q[f] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      st_q         <= StIdle;
      len_q        <= '0;
      bad_q        <= 1'b0;
      in_frame_q   <= 1'b0;
      frame_good_q <= 1'b0;
      frame_bad_q  <= 1'b0;
      frame_len_q  <= '0;
      good_q       <= '0;
      badc_q       <= '0;
      fault_q      <= '0;
      tmr_q[0]     <= '0;
      tmr_q[1]     <= '0;
    end else begin
      st_q         <= st_d;
      len_q        <= len_d;
      bad_q        <= bad_d;
      in_frame_q   <= (st_d == StFrame);
      frame_good_q <= close_good;
      frame_bad_q  <= close_bad;
      frame_len_q  <= frame_len_d;
      good_q       <= good_d;
      badc_q       <= badc_d;
      fault_q      <= fault_d;
      tmr_q[0]     <= tmr_d[0];
      tmr_q[1]     <= tmr_d[1];
    end
  end

  assign in_frame     = in_frame_q;
  assign frame_good   = frame_good_q;
  assign frame_bad    = frame_bad_q;
  assign frame_len    = frame_len_q;
  assign good_count   = good_q;
  assign bad_count    = badc_q;
  assign local_fault  = fault_q[0];
  assign remote_fault = fault_q[1];

endmodule

// File: tb/tb_xgmii_rx_frame_monitor.sv
// Directed bench for xgmii_rx_frame_monitor. Beats are driven on the falling
// edge; outputs for a beat are checked on the following falling edge.
module tb_xgmii_rx_frame_monitor;

  logic        rx_clk = 1'b0;
  logic        rx_rst;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic        cnt_clear;
  logic        in_frame, frame_good, frame_bad, local_fault, remote_fault;
  logic [15:0] frame_len;
  logic [31:0] good_count, bad_count;

  int total = 0;
  int bad = 0;

  localparam logic [63:0] DIdle   = 64'h0707070707070707;
  localparam logic [7:0]  CIdle   = 8'hFF;
  localparam logic [63:0] DStart0 = 64'hD5555555555555FB;
  localparam logic [7:0]  CStart0 = 8'h01;
  localparam logic [63:0] DData   = 64'hA5A5A5A5A5A5A5A5;
  localparam logic [7:0]  CData   = 8'h00;
  localparam logic [63:0] DTerm0  = 64'h07070707070707FD;
  localparam logic [7:0]  CTerm0  = 8'hFF;
  localparam logic [63:0] DStart4 = 64'h555555FB07070707;
  localparam logic [7:0]  CStart4 = 8'h1F;
  localparam logic [63:0] DErr3   = 64'h11111111FE111111;
  localparam logic [7:0]  CErr3   = 8'h08;
  localparam logic [63:0] DT2S4   = 64'h555555FB07FDAAAA;
  localparam logic [7:0]  CT2S4   = 8'h1C;
  localparam logic [63:0] DLfault = 64'h070707070100009C;
  localparam logic [7:0]  CLfault = 8'hF1;
  localparam logic [63:0] DRfault = 64'h0200009C07070707;
  localparam logic [7:0]  CRfault = 8'h1F;

  always #5 rx_clk = ~rx_clk;

  xgmii_rx_frame_monitor dut (
    .rx_clk       (rx_clk),
    .rx_rst       (rx_rst),
    .xgmii_rxd    (xgmii_rxd),
    .xgmii_rxc    (xgmii_rxc),
    .cnt_clear    (cnt_clear),
    .in_frame     (in_frame),
    .frame_good   (frame_good),
    .frame_bad    (frame_bad),
    .frame_len    (frame_len),
    .good_count   (good_count),
    .bad_count    (bad_count),
    .local_fault  (local_fault),
    .remote_fault (remote_fault)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one beat, then wait until its registered results are visible.
  task automatic step(input logic [63:0] d, input logic [7:0] c);
    xgmii_rxd = d;
    xgmii_rxc = c;
    @(negedge rx_clk);
  endtask

  task automatic chk_frame(input string tag, input logic g, input logic b, input logic [15:0] len);
    chk({tag, "_good"}, 64'(frame_good), 64'(g));
    chk({tag, "_bad"}, 64'(frame_bad), 64'(b));
    chk({tag, "_len"}, 64'(frame_len), 64'(len));
  endtask

  initial begin
    rx_rst    = 1'b1;
    cnt_clear = 1'b0;
    xgmii_rxd = DIdle;
    xgmii_rxc = CIdle;
    repeat (2) @(negedge rx_clk);
    chk("rst_in_frame", 64'(in_frame), 64'd0);
    chk_frame("rst", 1'b0, 1'b0, 16'd0);
    chk("rst_good_count", 64'(good_count), 64'd0);
    chk("rst_bad_count", 64'(bad_count), 64'd0);
    chk("rst_faults", 64'({local_fault, remote_fault}), 64'd0);
    rx_rst = 1'b0;

    // Clean frame from lane 0: 7 + 8*8 = 71 bytes.
    step(DIdle, CIdle);
    step(DIdle, CIdle);
    chk("idle_in_frame", 64'(in_frame), 64'd0);
    step(DStart0, CStart0);
    chk("s0_in_frame", 64'(in_frame), 64'd1);
    chk("s0_no_pulse", 64'({frame_good, frame_bad}), 64'd0);
    for (int i = 0; i < 8; i++) step(DData, CData);
    chk("data_in_frame", 64'(in_frame), 64'd1);
    step(DTerm0, CTerm0);
    chk_frame("f71", 1'b1, 1'b0, 16'd71);
    chk("f71_good_count", 64'(good_count), 64'd1);
    chk("f71_in_frame", 64'(in_frame), 64'd0);
    step(DIdle, CIdle);
    chk("f71_single_pulse", 64'(frame_good), 64'd0);

    // Lane 4 start, error character: 3 + 16 + 7 + 8 = 34 bytes, bad.
    step(DStart4, CStart4);
    step(DData, CData);
    step(DData, CData);
    step(DErr3, CErr3);
    step(DData, CData);
    step(DTerm0, CTerm0);
    chk_frame("err", 1'b0, 1'b1, 16'd34);
    chk("err_bad_count", 64'(bad_count), 64'd1);
    chk("err_in_frame", 64'(in_frame), 64'd0);

    // Oversize: 7 + 300*8 = 2407 bytes.
    step(DStart0, CStart0);
    for (int i = 0; i < 300; i++) step(DData, CData);
    step(DTerm0, CTerm0);
    chk_frame("big", 1'b0, 1'b1, 16'd2407);
    chk("big_bad_count", 64'(bad_count), 64'd2);

    // Idle inside a frame closes it bad.
    step(DStart0, CStart0);
    step(DIdle, CIdle);
    chk_frame("idle_close", 1'b0, 1'b1, 16'd7);
    chk("idle_close_in_frame", 64'(in_frame), 64'd0);

    // Start inside a frame: old bad (15 bytes), new one stays open.
    step(DStart0, CStart0);
    step(DData, CData);
    step(DStart0, CStart0);
    chk_frame("restart", 1'b0, 1'b1, 16'd15);
    chk("restart_in_frame", 64'(in_frame), 64'd1);
    step(DTerm0, CTerm0);
    chk_frame("restart_new", 1'b1, 1'b0, 16'd7);

    // Counter clear.
    cnt_clear = 1'b1;
    step(DIdle, CIdle);
    cnt_clear = 1'b0;
    chk("clear_counts", 64'({good_count, bad_count}), 64'd0);

    // Terminate lane 2 + start lane 4: 7+16+2 = 25, then 3+8 = 11.
    step(DStart0, CStart0);
    step(DData, CData);
    step(DData, CData);
    step(DT2S4, CT2S4);
    chk_frame("t2s4_first", 1'b1, 1'b0, 16'd25);
    chk("t2s4_in_frame", 64'(in_frame), 64'd1);
    chk("t2s4_good_count", 64'(good_count), 64'd1);
    step(DData, CData);
    chk("t2s4_gap", 64'({frame_good, frame_bad}), 64'd0);
    step(DTerm0, CTerm0);
    chk_frame("t2s4_second", 1'b1, 1'b0, 16'd11);
    chk("t2s4_good_count2", 64'(good_count), 64'd2);

    // Local fault: 3 ordered sets, then it must hold 127 idles and drop on the 128th.
    step(DLfault, CLfault);
    chk("lf_rise", 64'({local_fault, remote_fault}), 64'd2);
    step(DLfault, CLfault);
    step(DLfault, CLfault);
    for (int i = 0; i < 127; i++) step(DIdle, CIdle);
    chk("lf_hold", 64'(local_fault), 64'd1);
    step(DIdle, CIdle);
    chk("lf_fall", 64'(local_fault), 64'd0);
    step(DRfault, CRfault);
    chk("rf_rise", 64'({local_fault, remote_fault}), 64'd1);

    // Reset in the middle of a frame.
    step(DStart0, CStart0);
    step(DData, CData);
    rx_rst = 1'b1;
    #1;
    chk("mid_rst_in_frame", 64'(in_frame), 64'd0);
    chk("mid_rst_pulses", 64'({frame_good, frame_bad}), 64'd0);
    chk("mid_rst_counts", 64'({good_count, bad_count}), 64'd0);
    chk("mid_rst_faults", 64'({local_fault, remote_fault}), 64'd0);
    @(negedge rx_clk);
    rx_rst = 1'b0;
    step(DData, CData);
    chk("post_rst_no_frame", 64'({in_frame, frame_good, frame_bad}), 64'd0);
    step(DStart0, CStart0);
    step(DData, CData);
    step(DTerm0, CTerm0);
    chk_frame("post_rst", 1'b1, 1'b0, 16'd15);
    chk("post_rst_good_count", 64'(good_count), 64'd1);
    chk("post_rst_bad_count", 64'(bad_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
